uart_tx_core: RTL and testbench

//  UART transmitter, the transmit-side counterpart of the UART receive path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer.sv | 63 ++++++
 rtl/uart_tx_core.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, parity-type codes and the
// parity helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest payload the helper accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PAR_CALC_W = 64;

  function automatic logic parity_bit(input logic [PAR_CALC_W-1:0] data,
                                      input logic                  par_typ);
    return (par_typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Datapath of the UART transmitter: payload shift register, data-bit counter
// and the bit-period counter that paces every serial bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_run,
  input  logic                  i_bit_clr,
  input  logic                  i_shift,
  output logic                  o_lsb,
  output logic                  o_lsb_next,
  output logic                  o_tick,
  output logic                  o_last
);

  localparam int              CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [15:0]     PERIOD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [15:0]           r_period;

  // NOTE: nonblocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_period  <= '0;
    end else begin
      if (i_load) begin
        r_shift <= i_data;
      end else if (i_shift) begin
        r_shift <= r_shift >> 1;
      end

      if (i_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (i_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end

      // A load restarts the period so a back-to-back frame gets a full-length start bit.
      if (i_load || !i_run || o_tick) begin
        r_period <= '0;
      end else begin
        r_period <= r_period + 16'd1;
      end
    end
  end

  assign o_tick     = i_run && (r_period == PERIOD_MAX);
  assign o_last     = (r_bit_cnt == LAST_BIT);
  assign o_lsb      = r_shift[0];
  assign o_lsb_next = r_shift[1];

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_e r_state;
  logic        r_tx;
  logic        r_busy;
  logic        r_par_en;
  logic        r_par_bit;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_lsb;
  logic                  w_lsb_next;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_pe;
  logic                  w_load_pt;
  logic                  w_load_par;

`ifdef UART_TX_HOLD_EN
  logic                  r_hold_full;
  logic                  r_hold_pe;
  logic                  r_hold_pt;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  w_end_stop;
  logic                  w_use_hold;
  logic                  w_hold_wr;

  assign w_end_stop = (r_state == ST_STOP) && w_tick;
  assign w_use_hold = w_end_stop && r_hold_full;

  // A frame starts from the input when idle or when the stop bit ends with nothing queued.
  assign w_start = ((r_state == ST_IDLE) && DATA_VALID) ||
                   (w_end_stop && (r_hold_full || DATA_VALID));

  assign w_hold_wr = DATA_VALID && (!r_hold_full || w_use_hold) &&
                     !(w_start && !w_use_hold);

  assign w_load_data = w_use_hold ? r_hold_data : P_DATA;
  assign w_load_pe   = w_use_hold ? r_hold_pe   : PAR_EN;
  assign w_load_pt   = w_use_hold ? r_hold_pt   : PAR_TYP;

  // NOTE: the holding payload is reset along with its flag, so no stale byte survives RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_full <= 1'b0;
      r_hold_pe   <= 1'b0;
      r_hold_pt   <= 1'b0;
      r_hold_data <= '0;
    end else if (w_hold_wr) begin
      r_hold_full <= 1'b1;
      r_hold_pe   <= PAR_EN;
      r_hold_pt   <= PAR_TYP;
      r_hold_data <= P_DATA;
    end else if (w_use_hold) begin
      r_hold_full <= 1'b0;
    end
  end

  assign Busy = r_busy & r_hold_full;
`else
  assign w_start     = DATA_VALID && !r_busy;
  assign w_load_data = P_DATA;
  assign w_load_pe   = PAR_EN;
  assign w_load_pt   = PAR_TYP;
  assign Busy        = r_busy;
`endif

  assign w_load_par = parity_bit(PAR_CALC_W'(w_load_data), w_load_pt);

  uart_tx_serializer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_start),
    .i_data     (w_load_data),
    .i_run      (r_state != ST_IDLE),
    .i_bit_clr  ((r_state == ST_START) && w_tick),
    .i_shift    ((r_state == ST_DATA) && w_tick && !w_last),
    .o_lsb      (w_lsb),
    .o_lsb_next (w_lsb_next),
    .o_tick     (w_tick),
    .o_last     (w_last)
  );

  // TX_OUT is loaded with the level of the state being entered, so it never lags the FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_par_en  <= w_load_pe;
            r_par_bit <= w_load_par;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= w_lsb;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (!w_last) begin
              r_tx <= w_lsb_next;
            end else if (r_par_en) begin
              r_state <= ST_PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (w_start) begin
              r_state   <= ST_START;
              r_tx      <= 1'b0;
              r_par_en  <= w_load_pe;
              r_par_bit <= w_load_par;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: two instances (1 and 16 clocks per bit),
// a request-level reference model feeding per-instance queues, and a line monitor.
`timescale 1ns/1ps
module tb_uart_tx_core;

  localparam int DW   = 8;
  localparam int NI   = 2;
  localparam int CPB0 = 1;
  localparam int CPB1 = 16;

  typedef struct {
    int          start_cyc;
    int          nbits;
    logic [10:0] bits;
  } frame_t;

  logic            CLK = 1'b0;
  logic [NI-1:0]   rst = '1;
  logic [NI-1:0]   dv  = '0;
  logic [NI-1:0]   pe  = '0;
  logic [NI-1:0]   pt  = '0;
  logic [DW-1:0]   p_data [NI];
  logic            tx0, busy0, tx1, busy1;

  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  int     free_edge [NI];
  frame_t sbq0 [$];
  frame_t sbq1 [$];
  bit     mon_active [NI];
  int     mon_pos    [NI];
  frame_t mon_fr     [NI];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_core #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB0)) u_dut0 (
    .CLK(CLK), .RST(rst[0]), .P_DATA(p_data[0]), .DATA_VALID(dv[0]),
    .PAR_EN(pe[0]), .PAR_TYP(pt[0]), .TX_OUT(tx0), .Busy(busy0)
  );

  uart_tx_core #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB1)) u_dut1 (
    .CLK(CLK), .RST(rst[1]), .P_DATA(p_data[1]), .DATA_VALID(dv[1]),
    .PAR_EN(pe[1]), .PAR_TYP(pt[1]), .TX_OUT(tx1), .Busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int cpb_of(input int id);
    return (id == 0) ? CPB0 : CPB1;
  endfunction

  // Expected line levels, one entry per serial bit, derived from the frame rules.
  function automatic frame_t make_frame(input int start, input logic [DW-1:0] d,
                                        input logic pe_i, input logic pt_i);
    frame_t f;
    int     ones;
    ones        = $countones(d);
    f.start_cyc = start;
    f.bits      = '1;
    f.bits[0]   = 1'b0;
    for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
    if (pe_i) begin
      // Even: total number of ones including parity is even; odd: total is odd.
      f.bits[1+DW] = pt_i ? (ones % 2 == 0) : (ones % 2 == 1);
      f.nbits      = DW + 3;
    end else begin
      f.nbits = DW + 2;
    end
    f.bits[f.nbits-1] = 1'b1;
    return f;
  endfunction

  // Drive one cycle of request inputs; the model decides acceptance from its own timeline.
  task automatic drive(input int id, input logic v, input logic [DW-1:0] d,
                       input logic pe_i, input logic pt_i);
    int     edge_n;
    frame_t f;
    @(posedge CLK);
    #1;
    dv[id]     = v;
    p_data[id] = d;
    pe[id]     = pe_i;
    pt[id]     = pt_i;
    edge_n     = cyc + 1;
    if (v && !rst[id] && edge_n >= free_edge[id]) begin
      f             = make_frame(edge_n, d, pe_i, pt_i);
      free_edge[id] = edge_n + f.nbits * cpb_of(id) + 1;
      if (id == 0) sbq0.push_back(f);
      else         sbq1.push_back(f);
    end
  endtask

  task automatic idle_cycles(input int id, input int n);
    repeat (n) drive(id, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic random_cycles(input int id, input int n, input int inv_prob);
    repeat (n) drive(id, ($urandom_range(inv_prob - 1) == 0), 8'($urandom),
                     1'($urandom), 1'($urandom));
  endtask

  task automatic mon_step(input int id, input logic t, input logic b);
    frame_t f;
    int     c;
    int     qsize;
    c = cpb_of(id);
    if (rst[id]) begin
      mon_active[id] = 1'b0;
      check($sformatf("reset_tx%0d", id), 32'(t), 32'(1));
      check($sformatf("reset_busy%0d", id), 32'(b), 32'(0));
      return;
    end
    if (!mon_active[id]) begin
      if (t !== 1'b0) begin
        check($sformatf("idle_busy%0d", id), 32'(b), 32'(0));
        return;
      end
      qsize = (id == 0) ? sbq0.size() : sbq1.size();
      check($sformatf("frame_expected%0d", id), 32'(qsize > 0), 32'(1));
      if (qsize == 0) return;
      f              = (id == 0) ? sbq0.pop_front() : sbq1.pop_front();
      mon_fr[id]     = f;
      mon_active[id] = 1'b1;
      mon_pos[id]    = 0;
      check($sformatf("start_cycle%0d", id), cyc, f.start_cyc);
    end
    f = mon_fr[id];
    check($sformatf("line%0d_bit%0d_of_frame@%0d", id, mon_pos[id] / c, f.start_cyc),
          32'(t), 32'(f.bits[mon_pos[id] / c]));
    check($sformatf("frame_busy%0d", id), 32'(b), 32'(1));
    mon_pos[id]++;
    if (mon_pos[id] == f.nbits * c) mon_active[id] = 1'b0;
  endtask

  always @(negedge CLK) begin
    mon_step(0, tx0, busy0);
    mon_step(1, tx1, busy1);
  end

  initial begin
    p_data[0] = '0;
    p_data[1] = '0;
    for (int i = 0; i < NI; i++) begin
      free_edge[i]  = 0;
      mon_active[i] = 1'b0;
      mon_pos[i]    = 0;
    end
    repeat (3) @(posedge CLK);
    #2 rst = '0;

    // One clock per bit: directed frames.
    drive(0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle_cycles(0, 13);
    drive(0, 1'b1, 8'h01, 1'b1, 1'b1);
    idle_cycles(0, 12);
    drive(0, 1'b1, 8'h01, 1'b1, 1'b0);
    idle_cycles(0, 12);

    // Request mid-frame is refused.
    drive(0, 1'b1, 8'h3C, 1'b0, 1'b0);
    idle_cycles(0, 4);
    drive(0, 1'b1, 8'hC3, 1'b1, 1'b1);
    idle_cycles(0, 8);

    // Request held across the edge where Busy falls, with the payload changing every cycle.
    drive(0, 1'b1, 8'h5A, 1'b1, 1'b1);
    repeat (15) drive(0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
    idle_cycles(0, 14);

    // Reset during data bit 3 (bit 3 of 8'h96 is 0, so the line must jump high).
    drive(0, 1'b1, 8'h96, 1'b0, 1'b0);
    idle_cycles(0, 4);
    @(posedge CLK);
    #2 rst[0] = 1'b1;
    #1;
    check("async_reset_tx", 32'(tx0), 32'(1));
    check("async_reset_busy", 32'(busy0), 32'(0));
    check("sb0_empty_at_reset", 32'(sbq0.size()), 32'(0));
    sbq0.delete();
    free_edge[0] = 0;
    repeat (2) @(posedge CLK);
    #2 rst[0] = 1'b0;
    drive(0, 1'b1, 8'h6B, 1'b1, 1'b0);
    idle_cycles(0, 12);

    random_cycles(0, 1500, 4);
    idle_cycles(0, 20);

    // Sixteen clocks per bit.
    drive(1, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle_cycles(1, 165);
    random_cycles(1, 1200, 40);
    idle_cycles(1, 200);

    check("sb0_drained", 32'(sbq0.size()), 32'(0));
    check("sb1_drained", 32'(sbq1.size()), 32'(0));
    check("mon0_idle", 32'(mon_active[0]), 32'(0));
    check("mon1_idle", 32'(mon_active[1]), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
